move_button_poller: RTL

- Avalon-MM read initiator for the 4-bit button input PIO slave (registered readdata, no waitrequest, fixed read latency 1).
- Polls PIO data register (address 0) at a fixed rate, debounces the 4 buttons and detects press edges.
- Queues press events in a small FIFO for the game/robot-move logic through a valid/ready stream.
- Sits between the button PIO and the move controller; replaces software polling.

---
 rtl/move_button_poller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/move_button_poller.sv
// Avalon-MM poller for the 4-bit button PIO: periodic reads, debounce, press-edge event FIFO.
// Optional MOVE_POLL_IRQ_EN adds a registered irq output (FIFO non-empty or overflow).
module move_button_poller #(
    parameter int unsigned POLL_DIV   = 50000,
    parameter int unsigned DEB_COUNT  = 4,
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        evt_valid,
    output logic [3:0]  evt_data,
    input  logic        evt_ready,
    output logic [3:0]  btn_state,
    output logic        overflow,
`ifdef MOVE_POLL_IRQ_EN
    output logic        irq,
`endif
    input  logic        ovf_clear
);

    localparam int unsigned TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned NW = $clog2(DEB_COUNT + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      cand_q, cand_d;
    logic [NW-1:0]   n_q, n_d;
    logic [3:0]      stable_q, stable_d;
    logic [3:0]      sample, press;
    logic            push, pop, do_push, drop;
    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_d;
    logic            unused_readdata;

    assign unused_readdata = ^avm_readdata[31:4];
    assign avm_address     = 2'd0;
    assign avm_read        = (state_q == StIssue);
    assign sample          = avm_readdata[3:0] ^ ((ACTIVE_LOW != 0) ? 4'hF : 4'h0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (timer_q == TW'(POLL_DIV - 1)) begin
                    state_d = StIssue;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StIssue:   state_d = StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Debounce: candidate always tracks the latest sample; stable updates once it has held.
    always_comb begin
        cand_d   = cand_q;
        n_d      = n_q;
        stable_d = stable_q;
        press    = 4'h0;
        if (state_q == StCapture) begin
            cand_d = sample;
            if (sample == cand_q) begin
                n_d = (n_q < NW'(DEB_COUNT)) ? n_q + NW'(1) : n_q;
            end else begin
                n_d = NW'(1);
            end
            if (n_d >= NW'(DEB_COUNT)) begin
                stable_d = sample;
            end
            press = stable_d & ~stable_q;
        end
    end

    assign btn_state = stable_q;
    assign evt_valid = (count_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 4'h0;
    assign push      = (press != 4'h0);
    assign pop       = evt_valid & evt_ready;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    assign do_push   = push & ((count_q != CW'(FIFO_DEPTH)) | pop);
    assign drop      = push & ~do_push;

    always_comb begin
        count_d = count_q;
        if (do_push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && pop) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            cand_q   <= 4'h0;
            n_q      <= '0;
            stable_q <= 4'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cand_q   <= cand_d;
            n_q      <= n_d;
            stable_q <= stable_d;
            count_q  <= count_d;
            overflow <= overflow_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= press;
        end
    end

`ifdef MOVE_POLL_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= (count_d != '0) | overflow_d;
        end
    end
`endif

endmodule
